// File: rtl/forth_pkg.sv
// forth_pkg: definitions shared by the Forth core instruction memory and its
// boot loader.
//   boot_state_t       loader state encoding
//   FORTH_BOOT_MAGIC   start-of-frame byte of a boot image
//   FORTH_INSTR_WIDTH  instruction word width (byte packing assumes 16)
//   OP_NOP             no-operation instruction, handy for building images
package forth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam logic [7:0]  FORTH_BOOT_MAGIC  = 8'hF0;
    localparam int          FORTH_INSTR_WIDTH = 16;
    localparam logic [15:0] OP_NOP            = 16'he040;

endpackage

// File: rtl/forth_imem_ram.sv
// forth_imem_ram: single-clock simple dual-port RAM, 2**addr_width words,
// one write port and one registered read port (block-RAM inferable).
// Contents and the read register are deliberately not reset.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  RAM[raddr] from the previous cycle
module forth_imem_ram #(
    parameter int addr_width = 10,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] r_mem [0:(1 << addr_width)-1];
    logic [data_width-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/forth_boot_imem.sv
// forth_boot_imem: Forth core instruction memory with a byte-stream boot
// loader. After reset the core is held in reset while a framed image
//   magic, LEN_LO, LEN_HI, LEN x (lo byte, hi byte) [, CSUM]
// is written into RAM; a good frame releases the core. The read port serves
// the core with one cycle of latency in every state.
// Build option FORTH_BOOT_CSUM_EN: when defined the frame carries a trailing
// XOR checksum of the length and data bytes, checked before release; when
// undefined there is no checksum byte and the last data word releases the core.
//   clk         clock
//   reset_n     asynchronous active-low reset
//   rx_data     image byte;  rx_valid: byte valid;  rx_ready: always 1
//   iaddr       core fetch address;  idata: word for previous cycle's iaddr
//   cpu_reset   active-high core reset
//   load_done   image loaded, core running
//   load_error  last frame rejected
//
// state      | meaning
// IDLE       | waiting for magic, other bytes dropped
// LEN_LO     | expecting low length byte
// LEN_HI     | expecting high length byte, length checked here
// DATA_LO    | expecting low byte of next word
// DATA_HI    | expecting high byte, word written to RAM
// CSUM       | expecting checksum byte (checksum builds only)
// RUN        | core released, bytes dropped
// ERROR      | frame rejected, waiting for magic
module forth_boot_imem
    import forth_pkg::*;
#(
    parameter int         iaddr_width = 10,
    parameter int         instr_width = FORTH_INSTR_WIDTH,
    parameter logic [7:0] magic       = FORTH_BOOT_MAGIC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic [iaddr_width-1:0] iaddr,
    output logic [instr_width-1:0] idata,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int unsigned DEPTH = 32'd1 << iaddr_width;

`ifdef FORTH_BOOT_CSUM_EN
    localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam boot_state_t ST_AFTER_DATA = ST_RUN;
`endif

    boot_state_t            r_state;
    boot_state_t            w_state_next;
    logic                   w_accept;
    logic [15:0]            w_len;
    logic                   w_len_over;
    logic                   w_we;
    logic [instr_width-1:0] w_wdata;
    logic [instr_width-1:0] w_rdata;
    logic [7:0]             r_lo;
    logic [15:0]            r_count;
    logic [iaddr_width-1:0] r_wr_addr;
    logic                   r_cpu_reset;
    logic                   r_load_done;
    logic                   r_load_error;
    logic                   r_rd_en;
`ifdef FORTH_BOOT_CSUM_EN
    logic [7:0]             r_xor;
`endif

    assign rx_ready   = 1'b1;
    assign w_accept   = rx_valid && rx_ready;
    assign w_len      = {rx_data, r_lo};
    assign w_len_over = 32'(w_len) > DEPTH;
    assign w_wdata    = {rx_data, r_lo};
    assign w_we       = w_accept && (r_state == ST_DATA_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == magic) w_state_next = ST_LEN_LO;
                end
                ST_LEN_LO:  w_state_next = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (w_len_over)        w_state_next = ST_ERROR;
                    else if (w_len == '0)  w_state_next = ST_AFTER_DATA;
                    else                   w_state_next = ST_DATA_LO;
                end
                ST_DATA_LO: w_state_next = ST_DATA_HI;
                ST_DATA_HI: begin
                    // count still holds this word, so 1 means it is the last
                    if (r_count == 16'd1) w_state_next = ST_AFTER_DATA;
                    else                  w_state_next = ST_DATA_LO;
                end
`ifdef FORTH_BOOT_CSUM_EN
                ST_CSUM: begin
                    if (rx_data == r_xor) w_state_next = ST_RUN;
                    else                  w_state_next = ST_ERROR;
                end
`endif
                ST_RUN:     w_state_next = ST_RUN;
                ST_ERROR: begin
                    if (rx_data == magic) w_state_next = ST_LEN_LO;
                end
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Length, write pointer and checksum datapath. wr_addr wraps to 0 after
    // a full-depth image, which is harmless because the count ends the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo      <= '0;
            r_count   <= '0;
            r_wr_addr <= '0;
`ifdef FORTH_BOOT_CSUM_EN
            r_xor     <= '0;
`endif
        end else if (w_accept) begin
            case (r_state)
                ST_LEN_LO: begin
                    r_lo  <= rx_data;
`ifdef FORTH_BOOT_CSUM_EN
                    r_xor <= rx_data;
`endif
                end
                ST_LEN_HI: begin
                    r_count   <= w_len;
                    r_wr_addr <= '0;
`ifdef FORTH_BOOT_CSUM_EN
                    r_xor     <= r_xor ^ rx_data;
`endif
                end
                ST_DATA_LO: begin
                    r_lo  <= rx_data;
`ifdef FORTH_BOOT_CSUM_EN
                    r_xor <= r_xor ^ rx_data;
`endif
                end
                ST_DATA_HI: begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                    r_count   <= r_count - 16'd1;
`ifdef FORTH_BOOT_CSUM_EN
                    r_xor     <= r_xor ^ rx_data;
`endif
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so cpu_reset falls on
    // the same edge that enters RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_rd_en      <= 1'b0;
        end else begin
            r_cpu_reset  <= (w_state_next != ST_RUN);
            r_load_done  <= (w_state_next == ST_RUN);
            r_load_error <= (w_state_next == ST_ERROR);
            r_rd_en      <= 1'b1;
        end
    end

    forth_imem_ram #(
        .addr_width (iaddr_width),
        .data_width (instr_width)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_addr),
        .wdata (w_wdata),
        .raddr (iaddr),
        .rdata (w_rdata)
    );

    // The RAM read register has no reset; gating it gives idata a true
    // asynchronous reset value without costing a cycle of latency.
    assign idata      = r_rd_en ? w_rdata : '0;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

endmodule

// File: doc/forth_boot_imem.md
Name: forth_boot_imem

Overview:
Instruction memory for the Forth core, with a byte-stream boot loader in front of it. After reset it holds the core in reset and receives a framed program image from a byte source such as a UART receiver. It packs the bytes into 16-bit instructions, writes them into RAM, then releases the core. In run mode it serves the core's instruction port with a one-cycle synchronous read: the core presents iaddr (its next IP) and receives idata in the following cycle.

Parameters:
iaddr_width, 10, instruction address width; RAM depth is 2**iaddr_width words
instr_width, 16, instruction word width; fixed at 16, packing relies on it
magic, 8'hF0, start-of-frame byte

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  incoming image byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready
iaddr  in  iaddr_width  core fetch address (core's IP_next)
idata  out  instr_width  registered instruction for the iaddr of the previous cycle
cpu_reset  out  1  active-high reset to the Forth core
load_done  out  1  image loaded and verified; core running
load_error  out  1  last frame rejected

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: cpu_reset=1, load_done=0, load_error=0, idata=0, state=IDLE. RAM contents are not reset.
- Byte transfer: a byte transfers only on rx_valid && rx_ready. rx_ready=1 in every state, so the source is never stalled.
- Frame format: magic, LEN_LO, LEN_HI, then LEN words, each sent low byte first then high byte, then CSUM.
  - CSUM is the XOR of the LEN bytes and all data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN, ERROR.
- IDLE: if byte == magic, go to LEN_LO; any other byte is discarded.
- LEN_LO: latch the low length byte and initialise the XOR accumulator with it.
- LEN_HI: form len = {byte, lo}.
  - len > 2**iaddr_width: go to ERROR.
  - len == 0: go to CSUM.
  - Otherwise clear wr_addr and go to DATA_LO.
- DATA_LO: latch the low byte and fold it into the XOR.
- DATA_HI: write RAM[wr_addr] <= {byte, lo}, fold the byte into the XOR, increment wr_addr and decrement the remaining count.
  - Go to CSUM when the count reaches 0, else go to DATA_LO.
  - The count is 16-bit; len == 2**iaddr_width fills the RAM exactly and wr_addr wraps to 0 harmlessly.
- CSUM: if byte == XOR, go to RUN and set load_done=1; else go to ERROR and set load_error=1.
  - cpu_reset falls on the clock edge that enters RUN (registered output).
- RUN: cpu_reset=0, load_done=1. Bytes are accepted and discarded.
- ERROR: cpu_reset=1, load_error=1. Receiving magic clears load_error and goes to LEN_LO; other bytes are discarded.
- Load in progress (LEN_LO through CSUM): cpu_reset=1, load_done=0.
- Read port: idata <= RAM[iaddr] every cycle in all states, with 1-cycle latency. Write and read share no port conflict because the core is in reset while writes occur.
- Reset mid-load: the abort is immediate. Already-written words stay in RAM but are unverified; cpu_reset stays 1 until a full valid frame is received.
- Simultaneous events: none beyond a single byte per cycle; only one accept is possible per cycle.

Optional Feature:
FORTH_BOOT_CSUM_EN
- Defined: CSUM state, XOR accumulator and load_error-on-mismatch are present, as described above.
- Undefined: no CSUM byte in the frame, and no checksum check.
  - The last DATA_HI accept (or len == 0 in LEN_HI) goes directly to RUN.
  - load_error is raised only for oversize len.

Decomposition:
- Shared package forth_pkg:
  - boot state enum
  - FORTH_BOOT_MAGIC = 8'hF0
  - FORTH_INSTR_WIDTH = 16
  - OP_NOP = 16'he040 constant, so benches can build images
- Sub-module forth_imem_ram: single-clock RAM, 2**iaddr_width x 16, with one write port (we, waddr, wdata) and one registered read port (raddr, rdata), inferable as block RAM.
- The loader FSM lives in the top module.

Test Plan:
- Reset then frame F0 02 00 40 E0 01 80 XOR -> RAM[0]=E040, RAM[1]=8001; cpu_reset falls one cycle after the CSUM accept; load_done=1.
- Same frame with CSUM wrong by 0x01 -> load_error=1, cpu_reset stays 1; a following valid frame -> load_error=0, load_done=1.
- len=0x0401 with iaddr_width=10 -> ERROR after the LEN_HI byte, no RAM writes; len=0x0400 with 1024 words -> fills RAM, RUN.
- Garbage bytes 00 FF 12 before F0 -> ignored; load proceeds normally; rx_valid toggling 0/1 every cycle -> same RAM result.
- In RUN, drive iaddr=0 then 1 on consecutive cycles -> idata=E040 then 8001, each one cycle later; further rx bytes do not change RAM.
- Assert reset_n low mid-DATA -> outputs immediately return to reset values (cpu_reset=1, load_done=0, load_error=0, idata=0); a new full frame is required to reach RUN.
